// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole engine: state encoding, one-hot
// mole decode, per-level slot length and saturating arithmetic.
package mole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_SHOW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Widest mole field the decode helper can produce; callers truncate.
  localparam int MAX_MOLES = 64;

  function automatic logic [MAX_MOLES-1:0] onehot(input int idx, input int n_moles);
    onehot = '0;
    if (idx >= 0 && idx < n_moles && idx < MAX_MOLES) onehot[idx] = 1'b1;
  endfunction

  // Higher levels get shorter slots: level L lasts N_LEVELS+1-L ticks.
  function automatic int slot_ticks(input int lvl, input int n_levels);
    return n_levels + 1 - lvl;
  endfunction

  // Clamps a+b to the largest value representable in w bits (w <= 30).
  function automatic int sat_add(input int a, input int b, input int w);
    int max_v;
    int sum;
    max_v = (1 << w) - 1;
    sum   = a + b;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/mole_tick_prescaler.sv
// Game tick generator: one-cycle tick every TICK_CYCLES clocks. The counter
// runs 0..TICK_CYCLES-1 and is forced back to zero by clear so a new game
// always sees a full first tick.
module mole_tick_prescaler #(
  parameter int TICK_CYCLES = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_CYCLES - 1));

  // Free-running cycle counter, wraps on tick, restarts on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole game engine. One mole is lit per slot; a clean press of the
// lit button scores the current level, any other press or a slot timeout
// counts a miss. Slots shorten as the level rises.
//
// Optional build macro MOLE_NO_REPEAT_EN: when defined, a mole never
// appears at the same position in two consecutive slots.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEAD  | one blank tick before the first mole
// SHOW  | mole slots running
// DONE  | game over, results held until next start
module mole_game_core import mole_pkg::*; #(
  parameter int N_MOLES         = 4,
  parameter int TICK_CYCLES     = 100000000,
  parameter int N_LEVELS        = 3,
  parameter int MOLES_PER_LEVEL = 8,
  parameter int SCORE_W         = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [N_MOLES-1:0]              buttons_n,
  input  logic [$clog2(N_MOLES)-1:0]      rnd,
  output logic [N_MOLES-1:0]              leds,
  output logic [SCORE_W-1:0]              score,
  output logic [$clog2(N_LEVELS+1)-1:0]   level,
  output logic [SCORE_W-1:0]              misses,
  output logic                            busy,
  output logic                            done
);

  localparam int RW  = $clog2(N_MOLES);
  localparam int LW  = $clog2(N_LEVELS + 1);
  localparam int SLW = $clog2(N_LEVELS + 2);
  localparam int MCW = $clog2(MOLES_PER_LEVEL + 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] LEAD = ST_LEAD;
  localparam logic [1:0] SHOW = ST_SHOW;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]         state;
  logic [N_MOLES-1:0] prev_btn;
  logic [SLW-1:0]     slot_cnt;
  logic [MCW-1:0]     mole_cnt;
  logic               tick;
  logic               presc_clear;

  logic [N_MOLES-1:0] pressed;
  logic               press_evt;
  logic               hit;
  logic               wrong;
  logic               slot_end;
  logic               timeout;
  logic               last_mole;
  logic               last_level;
  logic [LW-1:0]      next_level;
  logic [SLW-1:0]     next_slot_len;
  logic [N_MOLES-1:0] next_leds;
  int                 idx_raw;

`ifdef MOLE_NO_REPEAT_EN
  logic [RW-1:0]      prev_idx;
`endif

  mole_tick_prescaler #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .tick  (tick)
  );

  assign presc_clear = start && (state == IDLE || state == DONE);

  // Press events are falling edges of the active-low buttons; a held button
  // therefore produces exactly one event.
  assign pressed    = prev_btn & ~buttons_n;
  assign press_evt  = (state == SHOW) && (leds != '0) && (pressed != '0);
  assign hit        = press_evt && (pressed == leds);
  assign wrong      = press_evt && !hit;
  assign slot_end   = (state == SHOW) && tick && (slot_cnt == SLW'(1));
  assign timeout    = slot_end && (leds != '0) && !press_evt;
  assign last_mole  = (mole_cnt == MCW'(MOLES_PER_LEVEL - 1));
  assign last_level = (level == LW'(N_LEVELS));

  // Level that the slot starting on this edge belongs to.
  assign next_level    = (state == SHOW && last_mole) ? level + LW'(1) : level;
  assign next_slot_len = SLW'(slot_ticks(int'(next_level), N_LEVELS));
  assign next_leds     = N_MOLES'(onehot(idx_raw, N_MOLES));

  // Fold the random index into range and optionally avoid a repeat.
  always_comb begin
    idx_raw = int'(rnd);
    if (idx_raw >= N_MOLES) idx_raw = idx_raw - N_MOLES;
`ifdef MOLE_NO_REPEAT_EN
    if (idx_raw == int'(prev_idx)) idx_raw = (idx_raw + 1) % N_MOLES;
`endif
  end

  // Previous-cycle button image for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_btn <= '1;
    end else begin
      prev_btn <= buttons_n;
    end
  end

`ifdef MOLE_NO_REPEAT_EN
  // Remember the position used by the slot that just started.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_idx <= RW'(N_MOLES - 1);
    end else if (presc_clear) begin
      prev_idx <= RW'(N_MOLES - 1);
    end else if ((state == LEAD && tick) || (slot_end && !(last_mole && last_level))) begin
      prev_idx <= RW'(idx_raw);
    end
  end
`endif

  // Game sequencing, slot timing, scoring and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      slot_cnt <= '0;
      mole_cnt <= '0;
      leds     <= '0;
      score    <= '0;
      level    <= '0;
      misses   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LEAD;
            score    <= '0;
            misses   <= '0;
            level    <= LW'(1);
            busy     <= 1'b1;
            done     <= 1'b0;
            leds     <= '0;
            mole_cnt <= '0;
            slot_cnt <= '0;
          end
        end
        LEAD: begin
          if (tick) begin
            state    <= SHOW;
            leds     <= next_leds;
            slot_cnt <= next_slot_len;
            mole_cnt <= '0;
          end
        end
        SHOW: begin
          if (hit) score <= SCORE_W'(sat_add(int'(score), int'(level), SCORE_W));
          if (wrong || timeout) misses <= SCORE_W'(sat_add(int'(misses), 1, SCORE_W));
          if (press_evt) leds <= '0;
          if (slot_end) begin
            if (last_mole && last_level) begin
              state <= DONE;
              leds  <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              leds     <= next_leds;
              slot_cnt <= next_slot_len;
              level    <= next_level;
              if (last_mole) begin
                mole_cnt <= '0;
              end else begin
                mole_cnt <= mole_cnt + MCW'(1);
              end
            end
          end else if (tick) begin
            slot_cnt <= slot_cnt - SLW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_core.sv
// Bench for mole_game_core: a game-level reference model (slot lengths in
// cycles, slot index arithmetic) checked every cycle, plus directed scenarios
// with hand-computed results and a randomized play phase.
module tb_mole_game_core;

  localparam int NM  = 4;
  localparam int TC  = 4;
  localparam int NL  = 3;
  localparam int MPL = 2;
  localparam int SW  = 3;
  localparam int RW  = $clog2(NM);
  localparam int LW  = $clog2(NL + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NM-1:0] buttons_n;
  logic [RW-1:0] rnd;
  logic [NM-1:0] leds;
  logic [SW-1:0] score;
  logic [LW-1:0] level;
  logic [SW-1:0] misses;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit hold_rnd = 1'b0;

  mole_game_core #(
    .N_MOLES         (NM),
    .TICK_CYCLES     (TC),
    .N_LEVELS        (NL),
    .MOLES_PER_LEVEL (MPL),
    .SCORE_W         (SW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .buttons_n (buttons_n),
    .rnd       (rnd),
    .leds      (leds),
    .score     (score),
    .level     (level),
    .misses    (misses),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 lead, 2 show, 3 done. m_left counts cycles left in the
  // current lead/slot period; m_slot counts finished slots of the game.
  int m_phase, m_left, m_slot, m_level, m_score, m_misses, m_leds, m_last;
  int m_busy, m_done, m_pressed;
  logic [NM-1:0] m_prev;

  function automatic int satw(input int v);
    return (v > (1 << SW) - 1) ? (1 << SW) - 1 : v;
  endfunction

  task automatic m_new_slot();
    int idx;
    idx = int'(rnd);
    if (idx >= NM) idx = idx - NM;
`ifdef MOLE_NO_REPEAT_EN
    if (idx == m_last) idx = (idx + 1) % NM;
`endif
    m_last = idx;
    m_leds = 1 << idx;
    m_left = (NL + 1 - m_level) * TC;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_left = 0; m_slot = 0; m_level = 0; m_score = 0;
      m_misses = 0; m_leds = 0; m_busy = 0; m_done = 0; m_last = NM - 1;
      m_prev = '1;
    end else begin
      m_pressed = int'(m_prev & ~buttons_n);
      m_prev = buttons_n;
      case (m_phase)
        0, 3: if (start) begin
          m_phase = 1; m_left = TC; m_score = 0; m_misses = 0; m_level = 1;
          m_busy = 1; m_done = 0; m_leds = 0; m_slot = 0; m_last = NM - 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2;
            m_new_slot();
          end
        end
        default: begin
          if (m_leds != 0 && m_pressed != 0) begin
            if (m_pressed == m_leds) m_score = satw(m_score + m_level);
            else m_misses = satw(m_misses + 1);
            m_leds = 0;
          end
          m_left--;
          if (m_left == 0) begin
            if (m_leds != 0) m_misses = satw(m_misses + 1);
            m_slot++;
            if (m_slot == NL * MPL) begin
              m_phase = 3; m_leds = 0; m_busy = 0; m_done = 1;
            end else begin
              m_level = m_slot / MPL + 1;
              m_new_slot();
            end
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("leds", int'(leds), m_leds);
      chk("score", int'(score), m_score);
      chk("level", int'(level), m_level);
      chk("misses", int'(misses), m_misses);
      chk("busy", int'(busy), m_busy);
      chk("done", int'(done), m_done);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    if (!hold_rnd) rnd = RW'($urandom_range(NM - 1));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int first_done;
    int waited;
    reset = 1'b1; start = 1'b0; buttons_n = '1; rnd = '0;
    steps(3);
    chk_en = 1'b1;
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_leds", int'(leds), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_misses", int'(misses), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // No presses: 4-cycle lead, then 12/12/8/8/4/4-cycle slots
    pulse_start();
    first_done = -1;
    for (int c = 0; c < 60; c++) begin
      if (c == 3) chk("lead_dark", int'(leds), 0);
      if (c == 4) chk("first_mole_lit", int'(leds != '0), 1);
      if (done && first_done < 0) first_done = c;
      step();
    end
    chk("done_latency", first_done, 52);
    chk("nopress_score", int'(score), 0);
    chk("nopress_misses", int'(misses), 6);

    // Perfect play, press one cycle after each mole appears
    pulse_start();
    waited = 0;
    while (!done && waited < 200) begin
      if (buttons_n != '1) begin
        buttons_n = '1;
        chk("hit_clears_leds", int'(leds), 0);
      end else if (leds != '0) begin
        buttons_n = ~leds;
      end
      step();
      waited++;
    end
    buttons_n = '1;
    chk("perfect_timeout", int'(done), 1);
    chk("perfect_score_sat", int'(score), 7);
    chk("perfect_misses", int'(misses), 0);
    chk("perfect_level", int'(level), NL);

    // Wrong button, then a late correct press in the same slot
    hold_rnd = 1'b1;
    rnd = RW'(2);
    pulse_start();
    steps(4);
    chk("wrong_mole", int'(leds), 4);
    buttons_n = 4'b1110;
    step();
    buttons_n = '1;
    chk("wrong_leds", int'(leds), 0);
    chk("wrong_misses", int'(misses), 1);
    chk("wrong_score", int'(score), 0);
    buttons_n = 4'b1011;
    step();
    buttons_n = '1;
    step();
    chk("late_misses", int'(misses), 1);
    chk("late_score", int'(score), 0);
    hold_rnd = 1'b0;

    // Reset in the middle of level 2
    waited = 0;
    while (level != LW'(2) && waited < 100) begin
      step();
      waited++;
    end
    chk("reach_level2", int'(level), 2);
    steps(3);
    #1 reset = 1'b1;
    #1;
    chk("async_leds", int'(leds), 0);
    chk("async_score", int'(score), 0);
    chk("async_level", int'(level), 0);
    chk("async_misses", int'(misses), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    step();
    reset = 1'b0;
    step();
    pulse_start();
    chk("restart_level", int'(level), 1);
    chk("restart_busy", int'(busy), 1);

    // Correct press sampled on the last cycle of a level-1 slot
    steps(4);
    chk("bnd_mole_lit", int'(leds != '0), 1);
    steps(11);
    buttons_n = ~leds;
    step();
    buttons_n = '1;
    chk("bnd_score", int'(score), 1);
    chk("bnd_misses", int'(misses), 0);
    chk("bnd_next_mole", int'(leds != '0), 1);

    // Random play with occasional (often ignored) start pulses
    for (int c = 0; c < 1500; c++) begin
      step();
      start = ($urandom_range(63) == 0);
      buttons_n = ($urandom_range(3) == 0) ? NM'($urandom_range((1 << NM) - 1)) : '1;
    end
    start = 1'b0;
    buttons_n = '1;
    waited = 0;
    while (busy && waited < 300) begin
      step();
      waited++;
    end
    chk("drain_idle", int'(busy), 0);

`ifdef MOLE_NO_REPEAT_EN
    hold_rnd = 1'b1;
    rnd = RW'(1);
    pulse_start();
    steps(4);
    chk("norep_slot0", int'(leds), 2);
    steps(12);
    chk("norep_slot1", int'(leds), 4);
    steps(12);
    chk("norep_slot2", int'(leds), 2);
    hold_rnd = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mole_game_core.md
Name: mole_game_core

Overview:
- Parametrised whack-a-mole game engine: N_MOLES active-high LEDs, active-low buttons, level-based speed-up, weighted scoring.
- Sits between the external random source / button synchroniser and the score display decoder.
- Start is an explicit pulse, not a reset toggle.
- Reports score, level, miss count and game status.

Parameters:
- N_MOLES, 4, number of LEDs/buttons (>=2)
- TICK_CYCLES, 100000000, clock cycles per game tick
- N_LEVELS, 3, number of levels; level L has slot length N_LEVELS+1-L ticks and is worth L points per hit
- MOLES_PER_LEVEL, 8, mole slots per level
- SCORE_W, 8, score width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle start pulse
- buttons_n  in  N_MOLES  active-low buttons, pre-synchronised; all ones = nothing pressed
- rnd  in  $clog2(N_MOLES)  free-running random index
- leds  out  N_MOLES  one-hot mole display, active high
- score  out  SCORE_W  accumulated points
- level  out  $clog2(N_LEVELS+1)  current level 1..N_LEVELS; 0 when idle
- misses  out  SCORE_W  wrong presses plus timeouts
- busy  out  1  game in progress
- done  out  1  game finished, held until next start or reset

Behaviour:
- Reset (async, any state including mid-game): state IDLE, tick/slot/mole counters cleared, leds=0, score=0, level=0, misses=0, busy=0, done=0, previous-button register=all ones.
- FSM: IDLE -> LEAD -> SHOW -> (SHOW | next level SHOW | DONE); DONE -> LEAD on start.
- IDLE/DONE: start=1 clears score and misses, sets level=1 and busy=1, clears done, and enters LEAD with the prescaler cleared. While busy, start is ignored.
- LEAD: leds=0 for exactly 1 tick (TICK_CYCLES cycles), then the first slot begins.
- Slot start: sample rnd into idx.
  - If rnd>=N_MOLES, idx=rnd-N_MOLES.
  - On the same edge, leds <= one-hot(idx) and the slot counter loads N_LEVELS+1-level ticks.
- Press event: a bit of buttons_n is 1 in the previous-cycle register and 0 now. Evaluate only while leds!=0.
  - Hit: the set of newly pressed bits equals leds exactly. On the next edge, score += level and leds <= 0.
  - Wrong: any other non-empty press set. On the next edge, misses += 1 and leds <= 0.
  - Held buttons generate no further events.
- Timeout: slot ends with leds still non-zero -> misses += 1. The next slot starts on the same edge.
- Next slot begins at the slot boundary regardless of early resolution. After MOLES_PER_LEVEL slots, level increments. After the final slot of level N_LEVELS, go to DONE: leds=0, busy=0, done=1, level keeps N_LEVELS.
- Arithmetic: score and misses saturate at 2^SCORE_W-1. The prescaler counts 0..TICK_CYCLES-1; its width is $clog2(TICK_CYCLES).
- Simultaneous events: a press event on the final cycle of a slot takes priority over timeout (hit scores, no miss), and the new slot still starts on that edge. Presses in LEAD, DONE, IDLE, or after resolution within a slot are ignored.

Optional Feature:
- Macro: MOLE_NO_REPEAT_EN.
- Defined: if the sampled idx equals the previous slot's idx, use (idx+1) mod N_MOLES. The previous idx resets to N_MOLES-1 at game start.
- Undefined: idx used as sampled; repeats allowed.

Decomposition:
- Package mole_pkg: state enum (IDLE, LEAD, SHOW, DONE), function onehot(idx, N_MOLES), function slot_ticks(level, N_LEVELS), saturating add function.
- Sub-module mole_tick_prescaler(clk, reset, clear, tick) generates a one-cycle tick every TICK_CYCLES cycles; the core instantiates it.

Test Plan (TICK_CYCLES=4, N_MOLES=4, N_LEVELS=3, MOLES_PER_LEVEL=2):
- No presses: start pulse -> leds=0 for 4 cycles, then 6 slots of 12/12/8/8/4/4 cycles. done=1 exactly 52 cycles after start; score=0, misses=6.
- Perfect play: press the correct button 1 cycle after each mole appears -> final score=12 (1+1+2+2+3+3), misses=0, leds clear 1 cycle after each press.
- Wrong button: rnd=2 (leds=0100), buttons_n=1110 -> leds=0000, misses=1, score unchanged. A later correct press in the same slot is ignored.
- Boundary press: correct press sampled on the last cycle of a level-1 slot -> score+1, misses unchanged, next mole shown on the same edge.
- Reset mid-game: assert reset during level 2 -> all outputs 0 immediately (asynchronously); start after release begins a fresh game at level 1.
- SCORE_W=3, extended perfect game -> score sticks at 7. With MOLE_NO_REPEAT_EN and rnd held at 1 -> leds alternate 0010, 0100.
